// File: rtl/sum_accumulator.sv
// Windowed saturating accumulator: sums up to COUNT accepted samples (or fewer on flush)
// and holds the total on a valid/ready output until the consumer takes it.
module sum_accumulator #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int COUNT     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic [7:0]           out_count,
    output logic                 out_overflow
);

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;
    localparam logic [7:0]           LAST    = 8'(COUNT - 1);

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0]   out_data_q, out_data_d;
    logic [7:0]             out_count_q, out_count_d;
    logic                   out_overflow_q, out_overflow_d;

    logic                   accept;
    logic                   close;
    logic [ACC_WIDTH:0]     sum;
    logic [ACC_WIDTH-1:0]   acc_inc;
    logic [7:0]             cnt_inc;
    logic                   ovf_inc;

    assign in_ready = (state_q == ACCUM) && !rst;
    assign accept   = in_valid && in_ready;

    // Window totals including this cycle's sample; one extra bit exposes the carry for clamping.
    always_comb begin
        sum     = {1'b0, acc_q} + (ACC_WIDTH + 1)'(in_data);
        acc_inc = acc_q;
        cnt_inc = cnt_q;
        ovf_inc = ovf_q;
        if (accept) begin
            acc_inc = sum[ACC_WIDTH] ? ACC_MAX : sum[ACC_WIDTH-1:0];
            cnt_inc = cnt_q + 8'd1;
            ovf_inc = ovf_q | sum[ACC_WIDTH];
        end
        close = (state_q == ACCUM) &&
                ((accept && (cnt_q == LAST)) || (flush && (cnt_inc != 8'd0)));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ACCUM;
            acc_q          <= '0;
            cnt_q          <= '0;
            ovf_q          <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_count_q    <= '0;
            out_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            ovf_q          <= ovf_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_count_q    <= out_count_d;
            out_overflow_q <= out_overflow_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM: if (close)     state_d = HOLD;
            HOLD:  if (out_ready) state_d = ACCUM;
            default:              state_d = ACCUM;
        endcase
    end

    always_comb begin
        acc_d          = acc_inc;
        cnt_d          = cnt_inc;
        ovf_d          = ovf_inc;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_count_d    = out_count_q;
        out_overflow_d = out_overflow_q;
        if (close) begin
            out_valid_d    = 1'b1;
            out_data_d     = acc_inc;
            out_count_d    = cnt_inc;
            out_overflow_d = ovf_inc;
            acc_d          = '0;
            cnt_d          = '0;
            ovf_d          = 1'b0;
        end else if ((state_q == HOLD) && out_ready) begin
            out_valid_d    = 1'b0;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_count    = out_count_q;
    assign out_overflow = out_overflow_q;

endmodule
